// File: rtl/gen_frame_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module : gen_frame_stim_pkg
// Brief  : Shared pattern-mode encodings and FSM state constants.
// Rev    : 1.0  initial release
// ============================================================================
package gen_frame_stim_pkg;

    typedef enum logic [1:0] {
        MODE_ROM   = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef logic [0:0] state_t;
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_RUN  = 1'b1;

    localparam int FRAME_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/gen_frame_stim_if.sv
`default_nettype none
// ============================================================================
// Module : gen_frame_stim_if
// Brief  : Control, ROM and pixel-stream bundle of the frame stimulus generator.
// Rev    : 1.0  initial release
// ============================================================================
interface gen_frame_stim_if
    import gen_frame_stim_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic                   start;
    logic                   continuous;
    logic [1:0]             mode;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_data;
    logic                   busy;
    logic                   vsync;
    logic                   data_vld;
    logic [DATA_W-1:0]      data;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    modport master (
        input  start, continuous, mode, rom_data,
        output rom_addr, busy, vsync, data_vld, data, frame_done, frame_cnt
    );

    modport slave (
        output start, continuous, mode, rom_data,
        input  rom_addr, busy, vsync, data_vld, data, frame_done, frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gen_frame_stim_pix.sv
`default_nettype none
// ============================================================================
// Module : gen_pix_pattern
// Brief  : Active-window decode, upscaled ROM address and test-pattern mux.
// Rev    : 1.0  initial release
// ============================================================================
module gen_pix_pattern
    import gen_frame_stim_pkg::*;
#(
    parameter int H_ACT_START = 9,
    parameter int H_ACT       = 112,
    parameter int V_ACT       = 112,
    parameter int SCALE       = 4,
    parameter int SRC_W       = 28,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int COL_W       = 7,
    parameter int ROW_W       = 7
) (
    input  logic              run,
    input  logic [COL_W-1:0]  col,
    input  logic [ROW_W-1:0]  row,
    input  mode_e             mode,
    output logic              active,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pat
);
    localparam int                SH     = $clog2(SCALE);
    // One extra bit so a window ending exactly at H_TOTAL cannot wrap.
    localparam logic [COL_W:0]    c_X_LO = (COL_W+1)'(H_ACT_START);
    localparam logic [COL_W:0]    c_X_HI = (COL_W+1)'(H_ACT_START + H_ACT);
    localparam logic [ROW_W-1:0]  c_Y_HI = ROW_W'(V_ACT);
    localparam logic [DATA_W-1:0] c_MSB  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [COL_W-1:0] w_x;
    logic [COL_W-1:0] w_xs;
    logic [ROW_W-1:0] w_ys;

    assign active = run && (row < c_Y_HI) &&
                    ({1'b0, col} >= c_X_LO) && ({1'b0, col} < c_X_HI);

    assign w_x  = col - c_X_LO[COL_W-1:0];
    assign w_xs = w_x >> SH;
    assign w_ys = row >> SH;
    assign addr = ADDR_W'(w_ys) * ADDR_W'(SRC_W) + ADDR_W'(w_xs);

    always_comb begin
        pat = '0;
        case (mode)
            MODE_GRAD:  pat = DATA_W'(w_x) + DATA_W'(row);
            MODE_CHECK: pat = (w_xs[0] ^ w_ys[0]) ? '1 : '0;
            MODE_CONST: pat = c_MSB;
            default:    pat = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/gen_frame_stim.sv
`default_nettype none
// ============================================================================
// Module : gen_frame_stim
// Brief  : Frame stimulus generator: vsync plus windowed, upscaled pixel stream.
// Rev    : 1.0  initial release
// ============================================================================
module gen_frame_stim
    import gen_frame_stim_pkg::*;
#(
    parameter int H_TOTAL     = 128,
    parameter int V_TOTAL     = 122,
    parameter int H_ACT_START = 9,
    parameter int H_ACT       = 112,
    parameter int V_ACT       = 112,
    parameter int SCALE       = 4,
    parameter int SRC_W       = 28,
    parameter int SRC_H       = 28,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    gen_frame_stim_if.master bus
);
    localparam int               COL_W      = $clog2(H_TOTAL);
    localparam int               ROW_W      = $clog2(V_TOTAL);
    localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(H_TOTAL - 1);
    localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(V_TOTAL - 1);

    if ((SRC_W * SCALE != H_ACT) || (SRC_H * SCALE != V_ACT)) begin : g_param_check
        $error("gen_frame_stim: active window must equal source size times SCALE");
    end

    state_t                 r_state;
    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    mode_e                  r_mode;
    logic                   r_busy;
    logic                   r_vsync;
    logic                   r_vld;
    logic                   r_use_rom;
    logic [DATA_W-1:0]      r_pat;
    logic                   r_done;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [ADDR_W-1:0]      r_addr_hold;

    logic                   w_run;
    logic                   w_line_end;
    logic                   w_frame_end;
    logic                   w_active;
    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_pat;

    assign w_run       = (r_state == c_ST_RUN);
    assign w_line_end  = (r_col == c_COL_LAST);
    assign w_frame_end = w_run && w_line_end && (r_row == c_ROW_LAST);

    gen_pix_pattern #(
        .H_ACT_START (H_ACT_START),
        .H_ACT       (H_ACT),
        .V_ACT       (V_ACT),
        .SCALE       (SCALE),
        .SRC_W       (SRC_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .COL_W       (COL_W),
        .ROW_W       (ROW_W)
    ) u_pix (
        .run    (w_run),
        .col    (r_col),
        .row    (r_row),
        .mode   (r_mode),
        .active (w_active),
        .addr   (w_addr),
        .pat    (w_pat)
    );

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state     <= c_ST_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= MODE_ROM;
            r_busy      <= 1'b0;
            r_vsync     <= 1'b0;
            r_vld       <= 1'b0;
            r_use_rom   <= 1'b0;
            r_pat       <= '0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
            r_addr_hold <= '0;
        end else begin
            r_vsync   <= w_run && (r_row == '0) && (r_col == COL_W'(1));
            r_vld     <= w_active;
            r_use_rom <= w_active && (r_mode == MODE_ROM);
            r_pat     <= w_active ? w_pat : '0;
            r_done    <= w_frame_end;
            if (w_active)
                r_addr_hold <= w_addr;
            if (w_frame_end)
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_ST_RUN;
                        r_busy  <= 1'b1;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_mode  <= mode_e'(bus.mode);
                    end
                end
                default: begin
                    if (w_frame_end) begin
                        r_col <= '0;
                        r_row <= '0;
                        // Next frame starts on this very edge when free-running.
                        if (bus.continuous) begin
                            r_mode <= mode_e'(bus.mode);
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_line_end) begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end else begin
                        r_col <= r_col + COL_W'(1);
                    end
                end
            endcase
        end
    end

    // ROM data returns one cycle after the address, in step with r_vld.
    assign bus.rom_addr   = w_active ? w_addr : r_addr_hold;
    assign bus.data       = r_use_rom ? bus.rom_data : r_pat;
    assign bus.busy       = r_busy;
    assign bus.vsync      = r_vsync;
    assign bus.data_vld   = r_vld;
    assign bus.frame_done = r_done;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule
`default_nettype wire

// File: tb/tb_gen_frame_stim.sv
`default_nettype none
// ============================================================================
// Module : tb_gen_frame_stim
// Brief  : Directed self-checking bench, default and reduced parameter sets.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gen_frame_stim;
    localparam int FA = 15616;   // default frame length
    localparam int FB = 800;     // reduced frame length

    logic sclk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    gen_frame_stim_if #(.ADDR_W(10), .DATA_W(8)) bus_a();
    gen_frame_stim_if #(.ADDR_W(6),  .DATA_W(8)) bus_b();

    gen_frame_stim dut_a (
        .sclk    (sclk),
        .s_rst_n (rst_a_n),
        .bus     (bus_a.master)
    );

    gen_frame_stim #(
        .H_TOTAL(40), .V_TOTAL(20), .H_ACT(16), .V_ACT(16),
        .SCALE(2), .SRC_W(8), .SRC_H(8), .ADDR_W(6)
    ) dut_b (
        .sclk    (sclk),
        .s_rst_n (rst_b_n),
        .bus     (bus_b.master)
    );

    // Source ROMs: contents = address, one-cycle read latency
    always @(posedge sclk) begin
        bus_a.rom_data <= bus_a.rom_addr[7:0];
        bus_b.rom_data <= {2'b00, bus_b.rom_addr};
    end

    function automatic logic [7:0] exp_a(input logic [1:0] m, input int x, input int y);
        case (m)
            2'd0:    return 8'(((y / 4) * 28 + x / 4) & 255);
            2'd1:    return 8'((x + y) & 255);
            2'd2:    return ((((x / 4) ^ (y / 4)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    // Stream monitors (sample on falling edge)
    int         vs_a[$], done_a[$], vs_b[$], done_b[$];
    int         vld_a, bad_a, pix_a, vld_b, bad_b, pix_b;
    logic [1:0] mode_q[$];
    logic [1:0] cur_mode = 2'd0;
    logic [7:0] d_first, d_x4, d_y4;
    logic       busy_done_a, busy_pre_a, busy_prev;

    always @(negedge sclk) begin
        if (bus_a.vsync === 1'b1) begin
            vs_a.push_back(cyc);
            pix_a = 0;
            if (mode_q.size() > 0) cur_mode = mode_q.pop_front();
        end
        if (bus_a.frame_done === 1'b1) begin
            done_a.push_back(cyc);
            busy_done_a = bus_a.busy;
            busy_pre_a  = busy_prev;
        end
        if (bus_a.data_vld === 1'b1) begin
            if (bus_a.data !== exp_a(cur_mode, pix_a % 112, pix_a / 112)) bad_a++;
            if (pix_a == 0)   d_first = bus_a.data;
            if (pix_a == 4)   d_x4    = bus_a.data;
            if (pix_a == 448) d_y4    = bus_a.data;
            vld_a++;
            pix_a++;
        end else if (bus_a.data !== 8'h00) begin
            bad_a++;
        end
        busy_prev = bus_a.busy;

        if (bus_b.vsync === 1'b1) begin
            vs_b.push_back(cyc);
            pix_b = 0;
        end
        if (bus_b.frame_done === 1'b1) done_b.push_back(cyc);
        if (bus_b.data_vld === 1'b1) begin
            if (bus_b.data !== 8'(((pix_b / 16) / 2) * 8 + (pix_b % 16) / 2)) bad_b++;
            vld_b++;
            pix_b++;
        end else if (bus_b.data !== 8'h00) begin
            bad_b++;
        end
    end

    task automatic clear_a();
        vs_a.delete(); done_a.delete(); mode_q.delete();
        vld_a = 0; bad_a = 0; pix_a = 0;
        busy_done_a = 1'bx; busy_pre_a = 1'bx;
    endtask

    task automatic clear_b();
        vs_b.delete(); done_b.delete();
        vld_b = 0; bad_b = 0; pix_b = 0;
    endtask

    task automatic pulse_a(output int k);
        @(negedge sclk); bus_a.start = 1'b1;
        @(negedge sclk); k = cyc; bus_a.start = 1'b0;
    endtask

    task automatic pulse_b(output int k);
        @(negedge sclk); bus_b.start = 1'b1;
        @(negedge sclk); k = cyc; bus_b.start = 1'b0;
    endtask

    task automatic test_reset();
        bus_a.start = 0; bus_a.continuous = 0; bus_a.mode = 0;
        bus_b.start = 0; bus_b.continuous = 0; bus_b.mode = 0;
        rst_a_n = 0; rst_b_n = 0;
        repeat (3) @(negedge sclk);
        #1;
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
        checks++; if (bus_a.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync: got %b want 0", bus_a.vsync); end
        checks++; if (bus_a.data_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus_a.data_vld); end
        checks++; if (bus_a.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus_a.data); end
        checks++; if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus_a.frame_done); end
        checks++; if (bus_a.frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus_a.frame_cnt); end
        checks++; if (bus_a.rom_addr !== 10'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus_a.rom_addr); end
        checks++; if (bus_b.rom_addr !== 6'h0) begin errors++; $display("FAIL reset_addr_b: got %h want 0", bus_b.rom_addr); end
        @(negedge sclk); rst_a_n = 1; rst_b_n = 1;
        @(negedge sclk);
    endtask

    task automatic test_one_shot();
        int k;
        clear_a(); mode_q.push_back(2'd0);
        bus_a.mode = 0; bus_a.continuous = 0;
        pulse_a(k);
        repeat (FA + 4) @(negedge sclk);
        #1;
        checks++; if (vs_a.size() != 1 || vs_a[0] != k + 2) begin errors++; $display("FAIL os_vsync: got n=%0d at %0d want 1 at %0d", vs_a.size(), vs_a[0], k + 2); end
        checks++; if (vld_a != 12544) begin errors++; $display("FAIL os_vld_count: got %0d want 12544", vld_a); end
        checks++; if (bad_a != 0) begin errors++; $display("FAIL os_pixels: got %0d bad want 0", bad_a); end
        checks++; if (d_first !== 8'd0) begin errors++; $display("FAIL os_first_pix: got %0d want 0", d_first); end
        checks++; if (d_x4 !== 8'd1) begin errors++; $display("FAIL os_pix_x4: got %0d want 1", d_x4); end
        checks++; if (d_y4 !== 8'd28) begin errors++; $display("FAIL os_pix_y4: got %0d want 28", d_y4); end
        checks++; if (done_a.size() != 1 || done_a[0] != k + FA) begin errors++; $display("FAIL os_done: got n=%0d at %0d want 1 at %0d", done_a.size(), done_a[0], k + FA); end
        checks++; if (busy_done_a !== 1'b0 || busy_pre_a !== 1'b1) begin errors++; $display("FAIL os_busy_fall: got %b%b want 10", busy_pre_a, busy_done_a); end
        checks++; if (bus_a.frame_cnt !== 16'd1) begin errors++; $display("FAIL os_cnt: got %0d want 1", bus_a.frame_cnt); end
    endtask

    task automatic test_continuous();
        int k;
        @(negedge sclk); rst_a_n = 0;
        @(negedge sclk); rst_a_n = 1;
        clear_a();
        mode_q.push_back(2'd2); mode_q.push_back(2'd3); mode_q.push_back(2'd1);
        bus_a.mode = 2; bus_a.continuous = 1;
        pulse_a(k);
        repeat (100) @(negedge sclk);
        bus_a.start = 1;                     // ignored while busy
        @(negedge sclk); bus_a.start = 0;
        repeat (4899) @(negedge sclk);
        bus_a.mode = 3;                      // must not affect frame 1
        repeat (FA) @(negedge sclk);
        bus_a.mode = 1;
        repeat (FA) @(negedge sclk);
        bus_a.continuous = 0;                // mid frame 3
        repeat (FA - 5000 + 6) @(negedge sclk);
        #1;
        checks++; if (vs_a.size() != 3) begin errors++; $display("FAIL ct_vsync_n: got %0d want 3", vs_a.size()); end
        checks++; if (vs_a[0] != k + 2 || vs_a[1] != k + FA + 2 || vs_a[2] != k + 2 * FA + 2) begin errors++; $display("FAIL ct_vsync_time: got %0d %0d %0d want %0d %0d %0d", vs_a[0], vs_a[1], vs_a[2], k + 2, k + FA + 2, k + 2 * FA + 2); end
        checks++; if (done_a.size() != 3 || done_a[2] != k + 3 * FA) begin errors++; $display("FAIL ct_done: got n=%0d last %0d want 3 at %0d", done_a.size(), done_a[2], k + 3 * FA); end
        checks++; if (vld_a != 3 * 12544) begin errors++; $display("FAIL ct_vld_count: got %0d want %0d", vld_a, 3 * 12544); end
        checks++; if (bad_a != 0) begin errors++; $display("FAIL ct_pixels: got %0d bad want 0", bad_a); end
        checks++; if (bus_a.frame_cnt !== 16'd3) begin errors++; $display("FAIL ct_cnt: got %0d want 3", bus_a.frame_cnt); end
        checks++; if (busy_done_a !== 1'b0 || busy_pre_a !== 1'b1) begin errors++; $display("FAIL ct_busy_fall: got %b%b want 10", busy_pre_a, busy_done_a); end
        checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL ct_idle: got busy %b want 0", bus_a.busy); end
    endtask

    task automatic test_reset_mid_line();
        int k;
        clear_a(); mode_q.push_back(2'd3);
        bus_a.mode = 3; bus_a.continuous = 0;
        pulse_a(k);
        repeat (2 * 128 + 50) @(negedge sclk);
        #1;
        checks++; if (bus_a.data_vld !== 1'b1 || bus_a.data !== 8'h80) begin errors++; $display("FAIL mr_pre_active: got vld %b data %h want 1 80", bus_a.data_vld, bus_a.data); end
        rst_a_n = 0;
        #1;
        checks++; if (bus_a.data_vld !== 1'b0 || bus_a.data !== 8'h00) begin errors++; $display("FAIL mr_pixel_zero: got vld %b data %h want 0 00", bus_a.data_vld, bus_a.data); end
        checks++; if (bus_a.busy !== 1'b0 || bus_a.vsync !== 1'b0 || bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL mr_ctrl_zero: got busy %b vsync %b done %b want 000", bus_a.busy, bus_a.vsync, bus_a.frame_done); end
        checks++; if (bus_a.rom_addr !== 10'h0 || bus_a.frame_cnt !== 16'h0) begin errors++; $display("FAIL mr_addr_cnt: got addr %h cnt %h want 0 0", bus_a.rom_addr, bus_a.frame_cnt); end
        @(negedge sclk); rst_a_n = 1;
        clear_a(); mode_q.push_back(2'd3);
        pulse_a(k);
        repeat (3) @(negedge sclk);
        #1;
        checks++; if (vs_a.size() != 1 || vs_a[0] != k + 2) begin errors++; $display("FAIL mr_restart_vsync: got n=%0d at %0d want 1 at %0d", vs_a.size(), vs_a[0], k + 2); end
    endtask

    task automatic test_small_params();
        int k;
        clear_b();
        bus_b.mode = 0; bus_b.continuous = 0;
        pulse_b(k);
        repeat (FB + 5) @(negedge sclk);
        #1;
        checks++; if (vld_b != 256) begin errors++; $display("FAIL sp_vld_count: got %0d want 256", vld_b); end
        checks++; if (bad_b != 0) begin errors++; $display("FAIL sp_pixels: got %0d bad want 0", bad_b); end
        checks++; if (vs_b.size() != 1 || vs_b[0] != k + 2) begin errors++; $display("FAIL sp_vsync: got n=%0d at %0d want 1 at %0d", vs_b.size(), vs_b[0], k + 2); end
        checks++; if (done_b.size() != 1 || done_b[0] != k + FB) begin errors++; $display("FAIL sp_frame_len: got n=%0d at %0d want 1 at %0d", done_b.size(), done_b[0], k + FB); end
        checks++; if (bus_b.rom_addr !== 6'd63) begin errors++; $display("FAIL sp_last_addr: got %0d want 63", bus_b.rom_addr); end
        checks++; if (bus_b.busy !== 1'b0 || bus_b.frame_cnt !== 16'd1) begin errors++; $display("FAIL sp_end_state: got busy %b cnt %0d want 0 1", bus_b.busy, bus_b.frame_cnt); end
    endtask

    task automatic test_frame_cnt_wrap();
        int k;
        @(negedge sclk); force dut_b.r_frame_cnt = 16'hFFFE;
        @(negedge sclk); release dut_b.r_frame_cnt;
        clear_b();
        bus_b.continuous = 1;
        pulse_b(k);
        repeat (FB + 5) @(negedge sclk);
        #1;
        checks++; if (bus_b.frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %h want ffff", bus_b.frame_cnt); end
        bus_b.continuous = 0;
        repeat (FB) @(negedge sclk);
        #1;
        checks++; if (bus_b.frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bus_b.frame_cnt); end
        checks++; if (done_b.size() != 2 || done_b[1] != k + 2 * FB) begin errors++; $display("FAIL wrap_done: got n=%0d last %0d want 2 at %0d", done_b.size(), done_b[1], k + 2 * FB); end
        checks++; if (bus_b.busy !== 1'b0) begin errors++; $display("FAIL wrap_idle: got busy %b want 0", bus_b.busy); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_continuous();
        test_reset_mid_line();
        test_small_params();
        test_frame_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
